// File: rtl/fixed_point_divider_if.sv
// rtl/fixed_point_divider_if.sv - start/busy/done handshake and operand/result bundle for fixed_point_divider
interface fixed_point_divider_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] input_dividend;
  logic [N-1:0] input_divisor;
  logic [N-1:0] output_q;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         div_by_zero;

  modport master (
    output start, input_dividend, input_divisor,
    input  output_q, busy, done, overflow, div_by_zero
  );

  modport slave (
    input  start, input_dividend, input_divisor,
    output output_q, busy, done, overflow, div_by_zero
  );
endinterface

// File: rtl/fixed_point_divider.sv
// rtl/fixed_point_divider.sv - signed Q(N-Q).Q restoring divider, one quotient bit per cycle; FIXED_POINT_DIVIDER_ROUND_EN enables round-half-away-from-zero
module fixed_point_divider #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input logic               clk,
  input logic               rst_n,
  fixed_point_divider_if.slave bus
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
  localparam logic [W:0]    ONE      = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]    MAX_NEG  = ONE << (N - 1);
  localparam logic [W:0]    MAX_POS  = MAX_NEG - ONE;
  localparam logic [N-1:0]  SAT_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  SAT_NEG  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   num_q, num_d;
  logic [N:0]     rem_q, rem_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   mag_b_q, mag_b_d;
  logic           sign_q, sign_d;
  logic           neg_a_q, neg_a_d;
  logic           zero_b_q, zero_b_d;
  logic [N-1:0]   out_q, out_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;
  logic           done_q, done_d;

  logic [N-1:0]   abs_a, abs_b;
  logic [N+1:0]   rem_shift;
  logic [N:0]     rem_sub;
  logic           rem_ge;
  logic [W:0]     mag_fin;

  // Operand magnitudes; the most negative value maps to 2^(N-1), still fits unsigned
  always_comb begin
    abs_a = bus.input_dividend[N-1] ? -bus.input_dividend : bus.input_dividend;
    abs_b = bus.input_divisor[N-1]  ? -bus.input_divisor  : bus.input_divisor;
  end

  // One restoring step: shift next numerator bit in and trial-subtract the divisor
  always_comb begin
    rem_shift = {rem_q, num_q[W-1]};
    rem_ge    = rem_shift >= {2'b00, mag_b_q};
    rem_sub   = rem_shift[N:0] - {1'b0, mag_b_q};
  end

  // Final quotient magnitude, optionally rounded half away from zero using the last remainder
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
  always_comb begin
    mag_fin = {1'b0, quot_q};
    if (!zero_b_q && ({rem_q, 1'b0} >= {2'b00, mag_b_q})) begin
      mag_fin = {1'b0, quot_q} + ONE;
    end
  end
`else
  always_comb begin
    mag_fin = {1'b0, quot_q};
  end
`endif

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      mag_b_q  <= '0;
      sign_q   <= 1'b0;
      neg_a_q  <= 1'b0;
      zero_b_q <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      mag_b_q  <= mag_b_d;
      sign_q   <= sign_d;
      neg_a_q  <= neg_a_d;
      zero_b_q <= zero_b_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  // Next-state: accept in IDLE, iterate N+Q times, then sign/saturate and pulse done
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    mag_b_d  = mag_b_q;
    sign_d   = sign_q;
    neg_a_d  = neg_a_q;
    zero_b_d = zero_b_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d   = bus.input_dividend[N-1] ^ bus.input_divisor[N-1];
          neg_a_d  = bus.input_dividend[N-1];
          zero_b_d = (bus.input_divisor == '0);
          mag_b_d  = abs_b;
          num_d    = {abs_a, {Q{1'b0}}};
          rem_d    = '0;
          quot_d   = '0;
          cnt_d    = CNT_INIT;
          state_d  = COMPUTE;
        end
      end

      COMPUTE: begin
        num_d  = {num_q[W-2:0], 1'b0};
        rem_d  = rem_ge ? rem_sub : rem_shift[N:0];
        quot_d = {quot_q[W-2:0], rem_ge};
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      FINISH: begin
        if (zero_b_q) begin
          out_d = neg_a_q ? SAT_NEG : SAT_POS;
          ovf_d = 1'b1;
          dbz_d = 1'b1;
        end else if (mag_fin > (sign_q ? MAX_NEG : MAX_POS)) begin
          out_d = sign_q ? SAT_NEG : SAT_POS;
          ovf_d = 1'b1;
          dbz_d = 1'b0;
        end else begin
          // Negating a zero magnitude yields zero, so -0 cannot appear
          out_d = sign_q ? -mag_fin[N-1:0] : mag_fin[N-1:0];
          ovf_d = 1'b0;
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.output_q    = out_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule
